bcd_timer_display: RTL

BCD_TIMER_DISPLAY -- requirements
Module: bcd_timer_display

---
 rtl/bcd_timer_display.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bcd_timer_display.sv
// bcd_timer_display: prescaled BCD up/down counter with a multiplexed
// 7-segment display driver.
//
// Parameters:
//   DIGITS   - number of BCD digits (1..4)
//   DIV      - clk cycles per count tick (>= 1)
//   SCAN_DIV - clk cycles each display digit stays selected (>= 1)
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - synchronous active-high reset
//   run      - count enable (0 = paused, prescaler held at 0)
//   clr      - synchronous clear of count and prescaler (highest priority)
//   down     - count direction (0 = up, 1 = down)
//   load     - synchronous load of load_val (invalid digits load as 0)
//   load_val - BCD preload value, digit 0 in bits [3:0]
//   count    - current BCD count, digit 0 in bits [3:0]
//   tc       - one-cycle pulse coincident with the wrapped value on count
//   seg      - registered segments {a,b,c,d,e,f,g}, active-high
//   dig_sel  - registered one-hot digit enable, bit i drives digit i
//
// Build option:
//   BCD_TIMER_BLANK_EN - when defined, leading zero digits (i > 0) are blanked.
module bcd_timer_display #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned DIV      = 50,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                clr,
  input  logic                down,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   dig_sel
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0] pre;
  logic [SW-1:0] scan;
  logic [IW-1:0] idx;

  logic          tick;
  logic [CW-1:0] cnt_up;
  logic [CW-1:0] cnt_dn;
  logic [CW-1:0] load_clean;
  logic          all_nine;
  logic          all_zero;
  logic          carry;
  logic          borrow;
  logic [3:0]    d;
  logic [3:0]    sel_digit;
  logic [6:0]    seg_next;

  // 7-segment decode, {a,b,c,d,e,f,g}
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  assign tick = run && (pre == PW'(DIV - 1));

  // Ripple increment/decrement across digits, wrap detection, load sanitising
  always_comb begin
    cnt_up     = count;
    cnt_dn     = count;
    load_clean = load_val;
    carry      = 1'b1;
    borrow     = 1'b1;
    all_nine   = 1'b1;
    all_zero   = 1'b1;
    d          = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d        = count[4*i +: 4];
      all_nine = all_nine & (d == 4'd9);
      all_zero = all_zero & (d == 4'd0);
      if (carry)  cnt_up[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
      if (borrow) cnt_dn[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
      carry  = carry & (d == 4'd9);
      borrow = borrow & (d == 4'd0);
      if (load_val[4*i +: 4] > 4'd9) load_clean[4*i +: 4] = 4'd0;
    end
  end

  // Digit currently being scanned
  always_comb begin
    sel_digit = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IW'(i)) sel_digit = count[4*i +: 4];
    end
  end

`ifdef BCD_TIMER_BLANK_EN
  logic zero_above;
  logic blank;

  // A digit above 0 is blank when it and every higher digit are zero
  always_comb begin
    zero_above = 1'b1;
    blank      = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above & (count[4*i +: 4] == 4'd0);
      if ((idx == IW'(i)) && (i != 0)) blank = zero_above;
    end
  end

  assign seg_next = blank ? 7'b0000000 : seg7(sel_digit);
`else
  assign seg_next = seg7(sel_digit);
`endif

  // Prescaler, counter, terminal count and display scan registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pre     <= '0;
      count   <= '0;
      tc      <= 1'b0;
      scan    <= '0;
      idx     <= '0;
      seg     <= 7'b0000000;
      dig_sel <= DIGITS'(1);
    end else begin
      tc <= 1'b0;
      if (clr) begin
        count <= '0;
        pre   <= '0;
      end else if (load) begin
        count <= load_clean;
        pre   <= '0;
      end else begin
        if (!run || tick) pre <= '0;
        else              pre <= pre + PW'(1);
        if (tick) begin
          count <= down ? cnt_dn : cnt_up;
          tc    <= down ? all_zero : all_nine;
        end
      end

      if (scan == SW'(SCAN_DIV - 1)) begin
        scan <= '0;
        idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        scan <= scan + SW'(1);
      end

      // seg and dig_sel come from the same index so they always agree
      seg     <= seg_next;
      dig_sel <= DIGITS'(1) << idx;
    end
  end

endmodule
